systolic_feeder: RTL and testbench

- Source side of the 4x4 systolic multiplier array. Accepts one A matrix and one B matrix per transaction through a valid/ready handshake.
- Streams A rows into the array's left inputs and B columns into its up inputs, in the diagonal skew the PE grid requires.
- Issues an accumulator-clear pulse before each stream.
- Signals completion once the last partial products have propagated through the grid: 3N-2 cycles after streaming starts.

---
 rtl/systolic_pkg.sv | 24 ++
 rtl/skew_lane_mux.sv | 32 +++
 rtl/systolic_feeder.sv | 129 ++++++++++++
 tb/tb_systolic_feeder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array source side: defaults, feeder states,
// sequence lengths and flattened matrix indexing.
package systolic_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_N          = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_e;

  // Streaming covers the full skew; the array's completion counter uses TOTAL_LEN.
  localparam int STREAM_LEN = 2 * DEF_N - 1;
  localparam int TOTAL_LEN  = 3 * DEF_N - 2;

  function automatic int elem_idx(input int r, input int c, input int n = DEF_N);
    return r * n + c;
  endfunction

endpackage

// File: rtl/skew_lane_mux.sv
// Picks the element one feeder lane presents at step t of the diagonal skew,
// or zero when the lane is outside its active window.
module skew_lane_mux import systolic_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N          = DEF_N,
  parameter int LANE       = 0,
  parameter int TW         = $clog2(3 * N),
  parameter bit TRANSPOSE  = 1'b0
) (
  input  logic [N*N*DATA_WIDTH-1:0] mat_i,
  input  logic [TW-1:0]             t_i,
  output logic [DATA_WIDTH-1:0]     elem_o
);

  // tap_t[bit][j]: candidate j gated by its step match; at most one j matches.
  logic [DATA_WIDTH-1:0][N-1:0] tap_t;

  for (genvar j = 0; j < N; j++) begin : g_tap
    // Row lanes walk along their row; column lanes walk down their column.
    localparam int E = TRANSPOSE ? elem_idx(j, LANE, N) : elem_idx(LANE, j, N);
    logic hit;
    assign hit = (int'(t_i) == LANE + j);
    for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
      assign tap_t[b][j] = hit & mat_i[E*DATA_WIDTH + b];
    end
  end

  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_or
    assign elem_o[b] = |tap_t[b];
  end

endmodule

// File: rtl/systolic_feeder.sv
// Captures one A/B pair, then clears the array, streams skewed rows/columns,
// waits for the grid to drain and pulses done. Every output is a flop.
module systolic_feeder import systolic_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N          = DEF_N
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N*N*DATA_WIDTH-1:0] mat_a_i,
  input  logic [N*N*DATA_WIDTH-1:0] mat_b_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [N*DATA_WIDTH-1:0]   left_o,
  output logic [N*DATA_WIDTH-1:0]   up_o,
  output logic                      clr_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int MW = N * N * DATA_WIDTH;
  localparam int TW = $clog2(3 * N);
  localparam logic [TW-1:0] T_STREAM_END = TW'(2 * N - 2);
  localparam logic [TW-1:0] T_DRAIN_END  = TW'(3 * N - 3);

  feeder_state_e state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [MW-1:0] mat_a_q, mat_a_d, mat_b_q, mat_b_d;

  logic [N-1:0][DATA_WIDTH-1:0] left_sel, up_sel;
  logic [N-1:0][DATA_WIDTH-1:0] left_q, left_d, up_q, up_d;
  logic ready_q, ready_d, busy_q, busy_d, clr_q, clr_d, done_q, done_d;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    mat_a_d = mat_a_q;
    mat_b_d = mat_b_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          mat_a_d = mat_a_i;
          mat_b_d = mat_b_i;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = STREAM;
        t_d     = '0;
      end
      STREAM: begin
        t_d = t_q + 1'b1;
        if (t_q == T_STREAM_END) state_d = DRAIN;
      end
      DRAIN: begin
        t_d = t_q + 1'b1;
        if (t_q == T_DRAIN_END) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        t_d     = '0;
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Lane selection runs on the next step so the flopped lanes line up with state.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_lane_mux #(
      .DATA_WIDTH(DATA_WIDTH), .N(N), .LANE(i), .TW(TW), .TRANSPOSE(1'b0)
    ) u_row (
      .mat_i (mat_a_q),
      .t_i   (t_d),
      .elem_o(left_sel[i])
    );
    skew_lane_mux #(
      .DATA_WIDTH(DATA_WIDTH), .N(N), .LANE(i), .TW(TW), .TRANSPOSE(1'b1)
    ) u_col (
      .mat_i (mat_b_q),
      .t_i   (t_d),
      .elem_o(up_sel[i])
    );
  end

  always_comb begin
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    clr_d   = (state_d == CLEAR);
    done_d  = (state_d == DONE);
    left_d  = (state_d == STREAM) ? left_sel : '0;
    up_d    = (state_d == STREAM) ? up_sel   : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      t_q     <= '0;
      mat_a_q <= '0;
      mat_b_q <= '0;
      left_q  <= '0;
      up_q    <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      mat_a_q <= mat_a_d;
      mat_b_q <= mat_b_d;
      left_q  <= left_d;
      up_q    <= up_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
    end
  end

  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign clr_o   = clr_q;
  assign done_o  = done_q;
  assign left_o  = left_q;
  assign up_o    = up_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a behavioural 4x4 output-stationary PE grid.
module tb_systolic_feeder;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int MW = N * N * DW;
  localparam int LW = N * DW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [MW-1:0] mat_a_i, mat_b_i;
  logic          valid_i;
  logic          ready_o, clr_o, busy_o, done_o;
  logic [LW-1:0] left_o, up_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  systolic_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .mat_a_i(mat_a_i),
    .mat_b_i(mat_b_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .left_o (left_o),
    .up_o   (up_o),
    .clr_o  (clr_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  // A moves right, B moves down, each PE accumulates a*b.
  logic [DW-1:0] a_in[N][N], b_in[N][N], a_pipe[N][N], b_pipe[N][N], acc[N][N];
  always_comb begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (c == 0) a_in[r][c] = left_o[r*DW +: DW];
        else        a_in[r][c] = a_pipe[r][c-1];
        if (r == 0) b_in[r][c] = up_o[c*DW +: DW];
        else        b_in[r][c] = b_pipe[r-1][c];
      end
  end
  always @(posedge clk_i) begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a_pipe[r][c] <= a_in[r][c];
        b_pipe[r][c] <= b_in[r][c];
        acc[r][c]    <= clr_o ? '0 : acc[r][c] + a_in[r][c] * b_in[r][c];
      end
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [DW-1:0] el(input logic [MW-1:0] m, input int r, input int c);
    return m[(r*N+c)*DW +: DW];
  endfunction

  function automatic logic [LW-1:0] exp_left(input logic [MW-1:0] a, input int t);
    logic [LW-1:0] v = '0;
    for (int r = 0; r < N; r++)
      if (t - r >= 0 && t - r < N) v[r*DW +: DW] = el(a, r, t - r);
    return v;
  endfunction

  function automatic logic [LW-1:0] exp_up(input logic [MW-1:0] b, input int t);
    logic [LW-1:0] v = '0;
    for (int c = 0; c < N; c++)
      if (t - c >= 0 && t - c < N) v[c*DW +: DW] = el(b, t - c, c);
    return v;
  endfunction

  function automatic logic [MW-1:0] rnd_mat();
    logic [MW-1:0] v;
    for (int i = 0; i < N * N; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  // Walks cycles +1..+13 after an accept edge and checks every output.
  task automatic follow(input logic [MW-1:0] a, input logic [MW-1:0] b,
                        input bit garbage, input bit hand, input bit e2e);
    for (int cyc = 1; cyc <= 13; cyc++) begin
      tick();
      if (cyc == 13) begin
        chk("ready_back", ready_o, 1);
        chk("busy_back", busy_o, 0);
        chk("done_back", done_o, 0);
        chk("left_idle", left_o, '0);
      end else begin
        chk($sformatf("clr_c%0d", cyc), clr_o, (cyc == 1) ? 1 : 0);
        chk($sformatf("done_c%0d", cyc), done_o, (cyc == 12) ? 1 : 0);
        chk($sformatf("busy_c%0d", cyc), busy_o, 1);
        chk($sformatf("ready_c%0d", cyc), ready_o, 0);
        chk($sformatf("left_c%0d", cyc), left_o,
            (cyc >= 2 && cyc <= 8) ? exp_left(a, cyc - 2) : '0);
        chk($sformatf("up_c%0d", cyc), up_o,
            (cyc >= 2 && cyc <= 8) ? exp_up(b, cyc - 2) : '0);
      end
      if (hand && cyc == 2) begin
        chk("hand_left_t0", left_o, 128'h1);
        chk("hand_up_t0", up_o, 128'h100);
      end
      if (hand && cyc == 5) begin
        chk("hand_left_t3", left_o, 128'h00000031_00000022_00000013_00000004);
        chk("hand_up_t3", up_o, 128'h00000103_00000112_00000121_00000130);
      end
      if (hand && cyc == 8) begin
        chk("hand_left_t6", left_o, 128'h00000034_00000000_00000000_00000000);
        chk("hand_up_t6", up_o, 128'h00000133_00000000_00000000_00000000);
      end
      if (e2e && cyc == 12)
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            chk($sformatf("pe_%0d_%0d", r, c), acc[r][c], el(b, r, c));
      if (cyc < 13) begin
        if (garbage) begin
          mat_a_i = rnd_mat();
          mat_b_i = rnd_mat();
          valid_i = 1'b1;
        end else begin
          valid_i = 1'b0;
        end
      end
    end
  endtask

  logic [MW-1:0] a1, b1, a2, b2, ai, be;
  bit seen_done;

  initial begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a1[(r*N+c)*DW +: DW] = 32'(16 * r + c + 1);
        b1[(r*N+c)*DW +: DW] = 32'(32'h100 + 16 * r + c);
        a2[(r*N+c)*DW +: DW] = 32'(32'hA000 + 16 * r + c);
        b2[(r*N+c)*DW +: DW] = 32'(32'hB0000 + 16 * r + c);
        ai[(r*N+c)*DW +: DW] = (r == c) ? 32'd1 : 32'd0;
        be[(r*N+c)*DW +: DW] = 32'(r * 4 + c);
      end
    valid_i = 1'b0;
    mat_a_i = '0;
    mat_b_i = '0;

    // Reset asserted before any clock edge
    #2 rst_i = 1'b1;
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_clr", clr_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_left", left_o, '0);
    chk("rst_up", up_o, '0);
    #17 rst_i = 1'b0;
    tick();
    chk("idle_ready", ready_o, 1);

    // Single transaction with hand-computed spot values
    mat_a_i = a1; mat_b_i = b1; valid_i = 1'b1;
    follow(a1, b1, 1'b0, 1'b1, 1'b0);

    // valid held high with toggling inputs while busy; second accept 13 cycles later
    mat_a_i = a1; mat_b_i = b1; valid_i = 1'b1;
    follow(a1, b1, 1'b1, 1'b0, 1'b0);
    mat_a_i = a2; mat_b_i = b2; valid_i = 1'b1;
    follow(a2, b2, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of streaming at t=2
    mat_a_i = a1; mat_b_i = b1; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick(); tick(); tick();
    chk("mid_left_t2", left_o, exp_left(a1, 2));
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_left", left_o, '0);
    chk("mid_rst_up", up_o, '0);
    chk("mid_rst_ready", ready_o, 1);
    chk("mid_rst_busy", busy_o, 0);
    tick();
    rst_i = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done_o) seen_done = 1'b1;
    end
    chk("no_done_after_rst", seen_done, 0);
    mat_a_i = a2; mat_b_i = b2; valid_i = 1'b1;
    follow(a2, b2, 1'b0, 1'b0, 1'b0);

    // End to end through the PE grid: identity times B gives B
    mat_a_i = ai; mat_b_i = be; valid_i = 1'b1;
    follow(ai, be, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
